audio_buffer_sched: RTL
=======================

Name: audio_buffer_sched

Overview:
- Command-driven scheduler that sequences the stereo sample buffer (Rx = raw capture, Tx = denoised result) for record and playback.
- Accepts user/host commands and paces buffer traffic with the codec sample ticks.
- Drives the buffer's request/stop handshake and returns playback samples to the DAC path.
- Sits between the board control logic (keys/host), the audio codec interface and the stereo buffer controller.

Parameters:
- MAX_SAMPLES, 16'hFFFE, record length limit in stereo samples (buffer data area size).
- REQ_TIMEOUT, 1023, cycles to wait for mem_req_ready before flagging an error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command strobe
- cmd_code  in  2  0=record Rx, 1=play Rx, 2=play Tx, 3=abort
- cmd_ready  out  1  high in IDLE; non-abort commands are accepted only when high
- adc_tick  in  1  one-cycle pulse per codec sample period, capture side
- adc_l, adc_r  in  16 each  ADC samples, valid on adc_tick
- dac_tick  in  1  one-cycle pulse per codec sample period, playback side
- dac_l, dac_r  out  16 each  playback sample, held between updates
- mem_req_valid  out  1  buffer request valid
- mem_req_type  out  1  0=read, 1=write
- mem_req_target  out  1  0=Rx, 1=Tx
- mem_stop  out  1  buffer address-advance inhibit
- mem_wdata_l, mem_wdata_r  out  16 each  write data
- mem_req_ready  in  1  buffer idle/accepting
- mem_busy  in  1  buffer session active
- mem_data_valid  in  1  read data valid
- mem_rdata_l, mem_rdata_r  in  16 each  read data
- active  out  1  session in progress
- done  out  1  one-cycle pulse on normal session end
- err  out  1  one-cycle pulse on timeout
- rec_count  out  16  samples written in the current or last recording

Behaviour:
- Reset values:
  - mem_req_valid=0, mem_stop=1, mem_req_type=0, mem_req_target=0.
  - wdata=0, dac_l=dac_r=0, rec_count=0, active=0, done=0, err=0.
  - State=IDLE.
  - Reset mid-session returns to IDLE immediately with these values. No done or err pulse is generated.
- States: IDLE, REC_REQ, REC_RUN, REC_END, PLAY_REQ, PLAY_RUN, WAIT_IDLE.
- IDLE:
  - cmd 0: go to REC_REQ, clear rec_count.
  - cmd 1 or 2: go to PLAY_REQ, mem_req_target = cmd_code[1].
  - cmd 3 in IDLE is ignored.
- REC_REQ:
  - mem_req_valid=1, type=1, target=0, stop=1.
  - On mem_req_ready=1, go to REC_RUN next cycle.
  - Timeout counter runs; reaching REQ_TIMEOUT gives err pulse, mem_req_valid=0, IDLE.
- REC_RUN:
  - mem_req_valid held 1 and stop=1 except for one write cycle per sample.
  - On adc_tick, latch adc_l/adc_r into mem_wdata.
  - Next cycle drives stop=0 for exactly one cycle and increments rec_count.
  - adc_tick during the write cycle is captured normally (no sample is lost at back-to-back ticks, minimum tick spacing is 2 cycles).
  - Leave to REC_END on abort, or when rec_count reaches MAX_SAMPLES (that final sample is written first).
- REC_END:
  - mem_req_valid=0 for one cycle to close the session, then WAIT_IDLE.
- PLAY_REQ:
  - mem_req_valid=1, type=0, stop=1.
  - On mem_req_ready, go to PLAY_RUN. Same timeout rule as REC_REQ.
- PLAY_RUN:
  - mem_req_valid=0, stop=1 except one cycle of stop=0 following each dac_tick.
  - Each mem_data_valid loads mem_rdata into dac_l/dac_r.
  - mem_busy falling means the buffer is exhausted: go to IDLE with a done pulse, dac outputs hold their last value.
  - Abort forces stop=1, dac outputs are zeroed, then WAIT_IDLE.
- WAIT_IDLE:
  - Wait for mem_busy=0, then IDLE.
  - done pulses on the exit cycle unless the session was aborted.
- Other rules:
  - active=1 in every state except IDLE.
  - cmd_valid outside IDLE: only code 3 acts; other codes are ignored with no side effect.
  - Abort and the MAX_SAMPLES limit in the same cycle: the final sample is written and the session counts as aborted (no done pulse).
  - rec_count never exceeds MAX_SAMPLES and holds its value after the session.

Optional Feature:
- Macro AUDIO_SCHED_LOOP_EN.
- When defined:
  - Adds input play_loop (1 bit).
  - In PLAY_RUN, buffer exhaustion with play_loop=1 returns to PLAY_REQ with the same target and no done pulse.
  - dac outputs hold their value across the re-request.
  - Abort still ends the session.
- When undefined:
  - No play_loop port.
  - Exhaustion always ends the session with a done pulse.

Test Plan:
- Record 4 samples: cmd 0, adc_tick every 8 cycles with adc_l=16'h0101..0404, abort after the 4th write.
  - rec_count=4.
  - Exactly 4 single-cycle stop=0 windows, wdata matching each sample.
  - No done pulse, IDLE after mem_busy falls.
- MAX_SAMPLES=3 override: record with continuous ticks.
  - Auto-stop after 3 writes, done pulse, rec_count=3.
- Play Tx: cmd 2, buffer model returns 16'hAAAA, 16'h5555 then drops busy.
  - target=1, dac_l sequences AAAA then 5555.
  - done pulse, dac holds 5555.
- Timeout: mem_req_ready held 0 after cmd 1.
  - err pulses exactly REQ_TIMEOUT cycles after entering PLAY_REQ.
  - mem_req_valid=0, IDLE.
- Reset mid-record after 2 samples:
  - Next cycle all outputs at reset values, cmd_ready=1, no done or err pulse.
- Busy command rejection: cmd 1 issued during REC_RUN.
  - Ignored, recording continues, target stays 0.

Source files
------------

// File: rtl/audio_buffer_sched.sv
// Record/playback sequencer for the stereo sample buffer, paced by codec ticks.
// Optional macro AUDIO_SCHED_LOOP_EN adds play_loop (re-request on exhaustion).
module audio_buffer_sched #(
  parameter logic [15:0] MAX_SAMPLES = 16'hFFFE,
  parameter int          REQ_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_code,
  output logic        cmd_ready,
  input  logic        adc_tick,
  input  logic [15:0] adc_l,
  input  logic [15:0] adc_r,
  input  logic        dac_tick,
  output logic [15:0] dac_l,
  output logic [15:0] dac_r,
  output logic        mem_req_valid,
  output logic        mem_req_type,
  output logic        mem_req_target,
  output logic        mem_stop,
  output logic [15:0] mem_wdata_l,
  output logic [15:0] mem_wdata_r,
  input  logic        mem_req_ready,
  input  logic        mem_busy,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_rdata_l,
  input  logic [15:0] mem_rdata_r,
`ifdef AUDIO_SCHED_LOOP_EN
  input  logic        play_loop,
`endif
  output logic        active,
  output logic        done,
  output logic        err,
  output logic [15:0] rec_count
);
  localparam int TW = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(REQ_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REC_REQ, S_REC_RUN, S_REC_END, S_PLAY_REQ, S_PLAY_RUN, S_WAIT_IDLE
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic          abrt_q, abrt_d;
  logic          busy_q;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   wdl_q, wdl_d, wdr_q, wdr_d;
  logic [15:0]   dacl_q, dacl_d, dacr_q, dacr_d;
  logic          tgt_q, tgt_d;
  logic          done_q, done_d, err_q, err_d;
  logic          abort, exhausted, loop_en;

  assign abort     = cmd_valid && (cmd_code == 2'd3);
  // Exhaustion is the falling edge of busy, so a late-rising busy is not mistaken for it.
  assign exhausted = busy_q && !mem_busy;
`ifdef AUDIO_SCHED_LOOP_EN
  assign loop_en = play_loop;
`else
  assign loop_en = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      abrt_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      wdl_q   <= '0;
      wdr_q   <= '0;
      dacl_q  <= '0;
      dacr_q  <= '0;
      tgt_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      abrt_q  <= abrt_d;
      busy_q  <= mem_busy;
      cnt_q   <= cnt_d;
      wdl_q   <= wdl_d;
      wdr_q   <= wdr_d;
      dacl_q  <= dacl_d;
      dacr_q  <= dacr_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    abrt_d  = abrt_q;
    cnt_d   = cnt_q;
    wdl_d   = wdl_q;
    wdr_d   = wdr_q;
    dacl_d  = dacl_q;
    dacr_d  = dacr_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        abrt_d = 1'b0;
        if (cmd_valid && cmd_code == 2'd0) begin
          state_d = S_REC_REQ;
          cnt_d   = '0;
          tgt_d   = 1'b0;
        end else if (cmd_valid && cmd_code != 2'd3) begin
          state_d = S_PLAY_REQ;
          tgt_d   = cmd_code[1];
        end
      end
      S_REC_REQ, S_PLAY_REQ: begin
        tmo_d = tmo_q + 1'b1;
        if (abort) begin
          state_d = S_WAIT_IDLE;
          abrt_d  = 1'b1;
        end else if (mem_req_ready) begin
          state_d = (state_q == S_REC_REQ) ? S_REC_RUN : S_PLAY_RUN;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_REC_RUN: begin
        // A write in flight this cycle always completes, even alongside abort.
        if (wr_q) cnt_d = cnt_q + 16'd1;
        if (abort) begin
          state_d = S_REC_END;
          abrt_d  = 1'b1;
        end else if (wr_q && (cnt_q + 16'd1) == MAX_SAMPLES) begin
          state_d = S_REC_END;
        end else if (adc_tick) begin
          wr_d  = 1'b1;
          wdl_d = adc_l;
          wdr_d = adc_r;
        end
      end
      S_REC_END: state_d = S_WAIT_IDLE;
      S_PLAY_RUN: begin
        if (mem_data_valid) begin
          dacl_d = mem_rdata_l;
          dacr_d = mem_rdata_r;
        end
        rd_d = dac_tick;
        if (abort) begin
          state_d = S_WAIT_IDLE;
          abrt_d  = 1'b1;
          rd_d    = 1'b0;
          dacl_d  = '0;
          dacr_d  = '0;
        end else if (exhausted) begin
          if (loop_en) begin
            state_d = S_PLAY_REQ;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (abort) abrt_d = 1'b1;
        if (!mem_busy) begin
          state_d = S_IDLE;
          done_d  = !(abrt_q || abort);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_type  = 1'b0;
    mem_stop      = 1'b1;
    case (state_q)
      S_REC_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_type  = 1'b1;
      end
      S_REC_RUN: begin
        mem_req_valid = 1'b1;
        mem_req_type  = 1'b1;
        mem_stop      = !wr_q;
      end
      S_PLAY_REQ: mem_req_valid = 1'b1;
      S_PLAY_RUN: mem_stop = !(rd_q && !abort);
      default: ;
    endcase
  end

  assign mem_req_target = tgt_q;
  assign mem_wdata_l    = wdl_q;
  assign mem_wdata_r    = wdr_q;
  assign dac_l          = dacl_q;
  assign dac_r          = dacr_q;
  assign rec_count      = cnt_q;
  assign active         = (state_q != S_IDLE);
  assign cmd_ready      = (state_q == S_IDLE);
  assign done           = done_q;
  assign err            = err_q;
endmodule
